// File: rtl/rle_pkg.sv
// Shared constants and FSM state encoding for the run-length encoder/decoder pair.
// Encoded word layout: {bit_id, run_len}, with the run length in the low CNT_W bits.
package rle_pkg;

  localparam int CNT_W   = 23;
  localparam int OUT_W   = 8;
  localparam int RD_LAT  = 2;
  localparam int WORD_W  = CNT_W + 1;
  localparam int ID_BIT  = CNT_W;
  localparam int CNT_LSB = 0;
  localparam int CNT_MSB = CNT_W - 1;
  localparam int FILL_W  = $clog2(OUT_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RD,
    LOAD,
    FILL,
    WRITE,
    FLUSH,
    DONE
  } dec_state_e;

endpackage

// File: rtl/rle_bit_packer.sv
// Combinational packer: works out how many bits of the current run fit in the
// byte being assembled and drops them into the buffer at the current fill position.
module rle_bit_packer
  import rle_pkg::*;
(
  input  logic [FILL_W-1:0] fill_cnt,
  input  logic [CNT_W-1:0]  rem,
  input  logic              bit_id,
  input  logic [OUT_W-1:0]  byte_buf,
  output logic [FILL_W-1:0] n,
  output logic [OUT_W-1:0]  byte_buf_next
);

  logic [FILL_W-1:0] space;
  logic [OUT_W-1:0]  run_mask;

  always_comb begin
    space = FILL_W'(OUT_W) - fill_cnt;
    if (rem < CNT_W'(space)) begin
      n = rem[FILL_W-1:0];
    end else begin
      n = space;
    end
    // Mask covers bits [fill_cnt, fill_cnt+n)
    run_mask = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if ((i >= int'(fill_cnt)) && (i < int'(fill_cnt) + int'(n))) begin
        run_mask[i] = 1'b1;
      end
    end
    byte_buf_next = bit_id ? (byte_buf | run_mask) : (byte_buf & ~run_mask);
  end

endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: pops {bit_id, run_len} words, re-expands each run and
// pushes the resulting bitstream out as LSB-first packed bytes.
module rle_dec
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              recv_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              rd_req,
  input  logic              send_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              wr_req,
  input  logic              end_of_stream,
  output logic              done
);

  localparam int LAT_W = $clog2(RD_LAT + 1);

  dec_state_e        state_q, state_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              done_q, done_d;
  logic              bit_id_q, bit_id_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [OUT_W-1:0]  byte_buf_q, byte_buf_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;

  logic [FILL_W-1:0] pack_n;
  logic [OUT_W-1:0]  pack_buf;

  rle_bit_packer u_packer (
    .fill_cnt      (fill_cnt_q),
    .rem           (rem_q),
    .bit_id        (bit_id_q),
    .byte_buf      (byte_buf_q),
    .n             (pack_n),
    .byte_buf_next (pack_buf)
  );

  always_comb begin
    state_d    = state_q;
    rd_req_d   = 1'b0;
    wr_req_d   = 1'b0;
    out_data_d = out_data_q;
    bit_id_d   = bit_id_q;
    rem_d      = rem_q;
    fill_cnt_d = fill_cnt_q;
    byte_buf_d = byte_buf_q;
    lat_cnt_d  = lat_cnt_q;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (recv_ready) begin
          rd_req_d  = 1'b1;
          lat_cnt_d = '0;
          state_d   = WAIT_RD;
        end else if (end_of_stream) begin
          state_d = (fill_cnt_q != '0) ? FLUSH : DONE;
        end
      end
      // rd_req is visible in the first WAIT_RD cycle; the word lands RD_LAT cycles later
      WAIT_RD: begin
        if (lat_cnt_q == LAT_W'(RD_LAT - 1)) begin
          state_d = LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      LOAD: begin
        bit_id_d = in_data[ID_BIT];
        rem_d    = in_data[CNT_MSB:CNT_LSB];
        state_d  = (in_data[CNT_MSB:CNT_LSB] == '0) ? REQ : FILL;
      end
      FILL: begin
        byte_buf_d = pack_buf;
        rem_d      = rem_q - CNT_W'(pack_n);
        fill_cnt_d = fill_cnt_q + pack_n;
        state_d    = (fill_cnt_d == FILL_W'(OUT_W)) ? WRITE : REQ;
      end
      WRITE, FLUSH: begin
        if (send_ready) begin
          wr_req_d   = 1'b1;
          out_data_d = byte_buf_q;
          byte_buf_d = '0;
          fill_cnt_d = '0;
          if (state_q == FLUSH) begin
            state_d = DONE;
          end else begin
            state_d = (rem_q != '0) ? FILL : REQ;
          end
        end
      end
      DONE: begin
        if (!end_of_stream) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_req_q   <= 1'b0;
      wr_req_q   <= 1'b0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      bit_id_q   <= 1'b0;
      rem_q      <= '0;
      fill_cnt_q <= '0;
      byte_buf_q <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rd_req_q   <= rd_req_d;
      wr_req_q   <= wr_req_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      bit_id_q   <= bit_id_d;
      rem_q      <= rem_d;
      fill_cnt_q <= fill_cnt_d;
      byte_buf_q <= byte_buf_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

  assign rd_req   = rd_req_q;
  assign wr_req   = wr_req_q;
  assign out_data = out_data_q;
  assign done     = done_q;

endmodule
